// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-side inputs, forwarding inputs and EX/MEM outputs of the
// RV32I execute stage, bundled so the stage connects through one port.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic            stall_e;
    logic            flush_e;
    logic            d_valid;
    logic [3:0]      d_alu_control;
    logic [XLEN-1:0] d_rs1_data;
    logic [XLEN-1:0] d_rs2_data;
    logic [XLEN-1:0] d_imm;
    logic            d_alu_src;
    logic [4:0]      d_rd;
    logic            d_reg_write;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [XLEN-1:0] mem_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;
    logic [XLEN-1:0] e_result;
    logic            e_zero;
    logic            m_valid;
    logic [XLEN-1:0] m_alu_result;
    logic [XLEN-1:0] m_write_data;
    logic [4:0]      m_rd;
    logic            m_reg_write;

    modport master (
        output stall_e, flush_e, d_valid, d_alu_control, d_rs1_data, d_rs2_data,
               d_imm, d_alu_src, d_rd, d_reg_write, fwd_a_sel, fwd_b_sel,
               mem_fwd_data, wb_fwd_data,
        input  e_result, e_zero, m_valid, m_alu_result, m_write_data, m_rd,
               m_reg_write
    );

    modport slave (
        input  stall_e, flush_e, d_valid, d_alu_control, d_rs1_data, d_rs2_data,
               d_imm, d_alu_src, d_rd, d_reg_write, fwd_a_sel, fwd_b_sel,
               mem_fwd_data, wb_fwd_data,
        output e_result, e_zero, m_valid, m_alu_result, m_write_data, m_rd,
               m_reg_write
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32I pipeline. ID/EX register (_p0),
// forwarding muxes, ALU, and EX/MEM register (_p1). e_result/e_zero are the
// combinational ALU outputs used for same-cycle branch resolution.
// Optional feature macro: EX_FORWARD_EN (forwarding muxes on operands A/B);
// when undefined the operands come only from the registered rs1/rs2.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);

    // ID/EX register
    logic            vld_p0;
    logic [3:0]      ctl_p0;
    logic [XLEN-1:0] rs1_p0;
    logic [XLEN-1:0] rs2_p0;
    logic [XLEN-1:0] imm_p0;
    logic            src_p0;
    logic [4:0]      rd_p0;
    logic            rw_p0;

    // EX/MEM register
    logic            vld_p1;
    logic [XLEN-1:0] res_p1;
    logic [XLEN-1:0] wdat_p1;
    logic [4:0]      rd_p1;
    logic            rw_p1;

    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] fwdb;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] result;

    function automatic logic [XLEN-1:0] alu_op(input logic [3:0] ctl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [4:0]             sh;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (ctl)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b1000: r = a ^ b;
            4'b0100: r = a << sh;
            4'b0110: r = a >> sh;
            4'b0111: r = sa >>> sh;
            4'b0101: r = {{(XLEN-1){1'b0}}, (sa < sb)};
            4'b1001: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1010: r = b << 12;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ID/EX capture: flush beats stall; stall holds the EX instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            ctl_p0 <= '0;
            rs1_p0 <= '0;
            rs2_p0 <= '0;
            imm_p0 <= '0;
            src_p0 <= 1'b0;
            rd_p0  <= '0;
            rw_p0  <= 1'b0;
        end else if (bus.flush_e) begin
            vld_p0 <= 1'b0;
            ctl_p0 <= '0;
            rs1_p0 <= '0;
            rs2_p0 <= '0;
            imm_p0 <= '0;
            src_p0 <= 1'b0;
            rd_p0  <= '0;
            rw_p0  <= 1'b0;
        end else if (!bus.stall_e) begin
            vld_p0 <= bus.d_valid;
            ctl_p0 <= bus.d_alu_control;
            rs1_p0 <= bus.d_rs1_data;
            rs2_p0 <= bus.d_rs2_data;
            imm_p0 <= bus.d_imm;
            src_p0 <= bus.d_alu_src;
            rd_p0  <= bus.d_rd;
            rw_p0  <= bus.d_reg_write;
        end
    end

`ifdef EX_FORWARD_EN
    // Operand selection: 10 MEM, 01 WB, 00/11 register file
    always_comb begin
        opa = rs1_p0;
        fwdb = rs2_p0;
        case (bus.fwd_a_sel)
            2'b10:   opa = bus.mem_fwd_data;
            2'b01:   opa = bus.wb_fwd_data;
            default: opa = rs1_p0;
        endcase
        case (bus.fwd_b_sel)
            2'b10:   fwdb = bus.mem_fwd_data;
            2'b01:   fwdb = bus.wb_fwd_data;
            default: fwdb = rs2_p0;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.fwd_a_sel, bus.fwd_b_sel, bus.mem_fwd_data, bus.wb_fwd_data};

    // Operand selection without forwarding: hazards are resolved by stalling
    always_comb begin
        opa = rs1_p0;
        fwdb = rs2_p0;
    end
`endif

    // ALU: operand B is the immediate when alu_src is set
    always_comb begin
        opb = src_p0 ? imm_p0 : fwdb;
        result = alu_op(ctl_p0, opa, opb);
    end

    assign bus.e_result = result;
    assign bus.e_zero   = (result == '0);

    // EX/MEM capture: a stall sends a bubble to MEM while EX re-executes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            wdat_p1 <= '0;
            rd_p1   <= '0;
            rw_p1   <= 1'b0;
        end else if (bus.stall_e) begin
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            wdat_p1 <= '0;
            rd_p1   <= '0;
            rw_p1   <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            res_p1  <= result;
            wdat_p1 <= fwdb;
            rd_p1   <= rd_p0;
            rw_p1   <= rw_p0 & vld_p0;
        end
    end

    assign bus.m_valid      = vld_p1;
    assign bus.m_alu_result = res_p1;
    assign bus.m_write_data = wdat_p1;
    assign bus.m_rd         = rd_p1;
    assign bus.m_reg_write  = rw_p1;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined RV32I core, directly downstream of the ALU decoder. Captures decoded operands and the 4-bit ALU control code into an ID/EX register, selects forwarded operands, performs the ALU operation, and registers the result into an EX/MEM register for the memory stage. Also drives a combinational zero flag and result for branch resolution in the same cycle.

## Interface

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall_e  input  1  hold the ID/EX register and insert a bubble into EX/MEM.
- flush_e  input  1  clear the ID/EX register to a bubble.
- d_valid  input  1  decode-stage instruction valid.
- d_alu_control  input  4  ALU code from the ALU decoder.
- d_rs1_data  input  XLEN  register-file operand A.
- d_rs2_data  input  XLEN  register-file operand B / store data.
- d_imm  input  XLEN  sign-extended immediate.
- d_alu_src  input  1  1 selects d_imm as ALU operand B.
- d_rd  input  5  destination register.
- d_reg_write  input  1  destination write enable.
- fwd_a_sel  input  2  operand-A source: 00 register, 01 WB, 10 MEM, 11 treated as 00.
- fwd_b_sel  input  2  operand-B source, same encoding as fwd_a_sel.
- mem_fwd_data  input  XLEN  forwarded MEM-stage result.
- wb_fwd_data  input  XLEN  forwarded WB-stage result.
- e_result  output  XLEN  combinational ALU result of the EX instruction.
- e_zero  output  1  combinational, e_result == 0.
- m_valid  output  1  EX/MEM valid.
- m_alu_result  output  XLEN  registered ALU result.
- m_write_data  output  XLEN  registered forwarded operand B before the immediate mux (store data).
- m_rd  output  5  registered destination.
- m_reg_write  output  1  registered write enable, gated by valid.

## Operation

- ID/EX register fields: valid, alu_control, rs1, rs2, imm, alu_src, rd, reg_write.
- Operand A is the forwarding-mux output. Operand B is the forwarding-mux output, replaced by imm when alu_src = 1.
- ALU codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 1000 xor.
  - 0100 sll, 0110 srl, 0111 sra; shift amount is B[4:0].
  - 0101 slt (signed), 1001 sltu (unsigned); result is 0 or 1.
  - 1010 result = B << 12.
  - 1011 to 1111 give result 0.
- All arithmetic is modulo 2^XLEN. Overflow is ignored and no carry flag is produced.
- Bubble: valid = 0, reg_write = 0, all other fields 0 (alu_control 0000 = add, so a bubble produces result 0).
- EX/MEM update each cycle:
  - Captures {valid, result, fwd B, rd, reg_write & valid}.
  - When stall_e = 1, captures a bubble instead.
- ID/EX update each cycle, in priority order:
  - flush_e = 1: bubble.
  - stall_e = 1: hold.
  - Otherwise: capture the d_* inputs.
- Simultaneous flush_e and stall_e: flush wins for ID/EX, and EX/MEM still takes a bubble.

## Timing

- Reset (asynchronous, while rst_n = 0): every register clears to 0.
  - m_valid = 0, m_reg_write = 0, m_alu_result = 0, m_write_data = 0, m_rd = 0.
  - e_result = 0 and e_zero = 1, because the ID/EX register holds a bubble.
- Latency:
  - d_* sampled at edge N appear at e_result/e_zero after edge N, in the same cycle as forwarding.
  - The result appears at m_alu_result after edge N+1.
- Forwarding data is used combinationally in the cycle the instruction sits in ID/EX; no registered path.
- During stall_e the EX instruction re-executes next cycle with fresh forwarding inputs.
- Reset deasserted mid-stream: first capture at the first rising edge with rst_n = 1.

## Configuration

- EX_FORWARD_EN defined: the forwarding muxes behave as described above.
- EX_FORWARD_EN undefined:
  - fwd_a_sel, fwd_b_sel, mem_fwd_data and wb_fwd_data are ignored.
  - The operands always come from the registered rs1 and rs2; the hazard unit must stall instead.
  - Ports remain present.

## Test plan

- Reset with rst_n = 0 mid-operation → all m_* outputs 0 immediately, e_zero = 1; after release, the first instruction is captured at the next edge.
- Basic ALU ops with rs1 = 0xFFFF_FFF0, rs2 = 0x0000_0004:
  - add = 0xFFFF_FFF4, sub = 0xFFFF_FFEC.
  - sra = 0xFFFF_FFFF, srl = 0x0FFF_FFFF.
  - slt = 1, sltu = 0.
- Code 1010 with alu_src = 1, imm = 0x0001_2345 → m_alu_result = 0x1234_5000. Code 1100 → result 0.
- Forwarding with EX_FORWARD_EN defined:
  - fwd_a_sel = 10, mem_fwd_data = 7, rs1 = 1, imm = 3, add → 10.
  - fwd_b_sel = 01, wb_fwd_data = 9, alu_src = 0 → m_write_data = 9.
  - fwd = 11 → register data used.
- Same stimulus with EX_FORWARD_EN undefined → operands from rs1/rs2 only: result = rs1 + imm = 4.
- Stall/flush sequence:
  - stall_e for 2 cycles → ID/EX held, m_valid = 0 both cycles, then the held result emerges once.
  - flush_e together with stall_e → the EX instruction is discarded and m_reg_write is never asserted for it.
